// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator streaming controller.
// Holds the controller state encoding, datapath widths and drain timeout.
package acc_pkg;

   localparam int IN_DATA_WIDTH     = 8;
   localparam int DWIDTH            = 16;
   localparam int AWIDTH            = 8;
   localparam int ACC_DRAIN_TIMEOUT = 15;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } acc_stream_state_t;

endpackage

// File: rtl/acc_fall_detect.sv
// Registers the accumulator valid and flags its falling edge.
// Ports: clk, reset (async high), valid_i, fall_o (1-cycle pulse).
module acc_fall_detect (
   input  logic clk,
   input  logic reset,
   input  logic valid_i,
   output logic fall_o
);

   logic valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) valid_q <= 1'b0;
      else       valid_q <= valid_i;
   end

   assign fall_o = valid_q & ~valid_i;

endmodule

// File: rtl/acc_stream_ctrl.sv
// Streams num_cnt_i operands from a sync-read memory into the accumulator,
// captures the final sum on result_o and pulses done_o.
// Ports: start_i/num_cnt_i command, mem_* read port, acc_* accumulator side,
// busy_o/done_o/result_o/err_o status.
// Optional macro ACC_STREAM_TIMEOUT_EN: drain watchdog driving err_o.
module acc_stream_ctrl
   import acc_pkg::*;
#(
   parameter int IN_DATA_WIDTH = acc_pkg::IN_DATA_WIDTH,
   parameter int DWIDTH        = acc_pkg::DWIDTH,
   parameter int AWIDTH        = acc_pkg::AWIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic [AWIDTH:0]          num_cnt_i,
   output logic                     mem_ce_o,
   output logic [AWIDTH-1:0]        mem_addr_o,
   input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
   output logic                     acc_run_o,
   output logic                     acc_valid_o,
   output logic [IN_DATA_WIDTH-1:0] acc_number_o,
   input  logic                     acc_valid_i,
   input  logic [DWIDTH-1:0]        acc_result_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [DWIDTH-1:0]        result_o,
   output logic                     err_o
);

   acc_stream_state_t state_q, state_d;
   logic [AWIDTH:0]   cnt_q, cnt_d;
   logic [AWIDTH:0]   idx_q, idx_d;
   logic [DWIDTH-1:0] result_q, result_d;
   logic              valid_q;
   logic              fall;

`ifdef ACC_STREAM_TIMEOUT_EN
   logic [3:0] wdog_q, wdog_d;
   logic       err_q, err_d;
`endif

   acc_fall_detect u_fall (
      .clk     (clk),
      .reset   (reset),
      .valid_i (acc_valid_i),
      .fall_o  (fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
`ifdef ACC_STREAM_TIMEOUT_EN
         wdog_q   <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         valid_q  <= mem_ce_o;
`ifdef ACC_STREAM_TIMEOUT_EN
         wdog_q   <= wdog_d;
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      result_d = result_q;
`ifdef ACC_STREAM_TIMEOUT_EN
      wdog_d   = '0;
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               cnt_d   = num_cnt_i;
               state_d = CLEAR;
`ifdef ACC_STREAM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         CLEAR: begin
            idx_d = '0;
            if (cnt_q == '0) begin
               result_d = '0;
               state_d  = DONE;
            end else begin
               state_d  = STREAM;
            end
         end
         STREAM: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == cnt_q - 1'b1) state_d = DRAIN;
         end
         DRAIN: begin
            if (fall) begin
               result_d = acc_result_i;
               state_d  = DONE;
            end
`ifdef ACC_STREAM_TIMEOUT_EN
            // wdog_q == limit-1 marks the last of the allowed drain cycles
            else if (wdog_q == 4'(ACC_DRAIN_TIMEOUT - 1)) begin
               err_d    = 1'b1;
               result_d = '0;
               state_d  = DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_ce_o     = (state_q == STREAM);
   assign mem_addr_o   = idx_q[AWIDTH-1:0];
   assign acc_run_o    = (state_q == CLEAR);
   assign acc_valid_o  = valid_q;
   // the accumulator adds number_i once after valid falls; feed it zero
   assign acc_number_o = valid_q ? mem_q_i : '0;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign result_o     = result_q;

`ifdef ACC_STREAM_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
